// File: rtl/decoder_nofm_scan.sv
// Registered one-of-N active-low decoder with direct and prescaled scan modes.
// Optional break-before-make blanking on scan steps: DECODER_SCAN_BLANK_EN.
//
// Ports:
//   clk      system clock, all state updates on rising edge
//   reset    synchronous active-high reset
//   en       1 = outputs live, 0 = outputs forced high and state held
//   mode     0 = direct decode of code_in, 1 = scan
//   code_in  direct-mode code, scan-mode load value
//   load     scan mode: jump index to code_in
//   div      scan step period is div+1 clk cycles
//   out_n    registered active-low one-hot output
//   idx      index currently driven on out_n
//   wrap     one-cycle pulse on the OUT_N-1 -> 0 scan step
//   err      out-of-range code (direct) or illegal load (scan)
module decoder_nofm_scan #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_N = 10,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic [IN_W-1:0]  code_in,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_N-1:0] out_n,
  output logic [IN_W-1:0]  idx,
  output logic             wrap,
  output logic             err
);

  if (OUT_N < 2 || OUT_N > (1 << IN_W)) begin : g_bad_out_n
    $error("decoder_nofm_scan: OUT_N must be in 2..2**IN_W");
  end

`ifdef DECODER_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [IN_W-1:0] LAST = IN_W'(OUT_N - 1);

  logic [OUT_N-1:0] r_out_n;
  logic [IN_W-1:0]  r_idx;
  logic [DIV_W-1:0] r_pre;
  logic             r_wrap;
  logic             r_err;

  logic [OUT_N-1:0] w_out_n;
  logic [IN_W-1:0]  w_idx;
  logic [DIV_W-1:0] w_pre;
  logic             w_wrap;
  logic             w_err;
  logic             w_step;
  logic             w_in_range;

  function automatic logic [OUT_N-1:0] f_decode(
    input logic [IN_W-1:0] k
  );
    logic [OUT_N-1:0] v;
    v = '1;
    for (int i = 0; i < int'(OUT_N); i++) begin
      if (k == IN_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  // OUT_N may equal 2**IN_W, so compare in 32 bits.
  assign w_in_range = (32'(code_in) < 32'(OUT_N));

  always_comb begin
    w_out_n = r_out_n;
    w_idx   = r_idx;
    w_pre   = r_pre;
    w_wrap  = 1'b0;
    w_err   = r_err;
    w_step  = 1'b0;
    if (!en) begin
      w_out_n = '1;
    end else if (!mode) begin
      w_pre   = '0;
      w_err   = !w_in_range;
      if (w_in_range) w_idx = code_in;
      w_out_n = f_decode(code_in);
    end else begin
      if (load) begin
        w_step = 1'b1;
        w_pre  = '0;
        w_idx  = w_in_range ? code_in : '0;
        w_err  = !w_in_range;
      end else if (r_pre == div) begin
        w_step = 1'b1;
        w_pre  = '0;
        w_wrap = (r_idx == LAST);
        w_idx  = (r_idx == LAST) ? '0
                                 : r_idx + IN_W'(1);
      end else begin
        // Natural wrap past 2**DIV_W-1 if div was lowered.
        w_pre = r_pre + DIV_W'(1);
      end
      w_out_n = (BLANK && w_step) ? '1
                                  : f_decode(w_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_n <= '1;
      r_idx   <= '0;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_out_n <= w_out_n;
      r_idx   <= w_idx;
      r_pre   <= w_pre;
      r_wrap  <= w_wrap;
      r_err   <= w_err;
    end
  end

  assign out_n = r_out_n;
  assign idx   = r_idx;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_decoder_nofm_scan.sv
// Directed-vector bench for decoder_nofm_scan (IN_W=4, OUT_N=10, DIV_W=8).
// Blank-step expectations follow DECODER_SCAN_BLANK_EN when defined.
module tb_decoder_nofm_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       mode;
  logic [3:0] code_in;
  logic       load;
  logic [7:0] div;
  logic [9:0] out_n;
  logic [3:0] idx;
  logic       wrap;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

`ifdef DECODER_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  decoder_nofm_scan #(
    .IN_W(4), .OUT_N(10), .DIV_W(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .mode(mode), .code_in(code_in),
    .load(load), .div(div),
    .out_n(out_n), .idx(idx),
    .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dec(input int k);
    logic [9:0] v;
    v = 10'h3FF;
    if (k >= 0 && k < 10) v[k] = 1'b0;
    return v;
  endfunction

  function automatic logic [9:0] sout(input int k);
    return BLANK ? 10'h3FF : dec(k);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = 1'b0;
    code_in = 4'd3; load = 1'b0; div = 8'd0;
    #1;

    // 1: reset then release
    repeat (3) tick();
    chk("rst_out", 32'(out_n), 32'h3FF);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wrap", 32'(wrap), 0);
    reset = 1'b0;
    tick();
    chk("rel_out", 32'(out_n), 32'h3F7);
    chk("rel_idx", 32'(idx), 3);

    // 2: direct sweep
    for (int k = 0; k < 16; k++) begin
      code_in = 4'(k);
      tick();
      chk("dir_out", 32'(out_n), 32'(dec(k)));
      chk("dir_err", 32'(err), (k >= 10) ? 1 : 0);
      chk("dir_idx", 32'(idx), (k < 10) ? k : 9);
      chk("dir_wrap", 32'(wrap), 0);
    end

    // 3: scan div=2 from idx 0
    code_in = 4'd0;
    tick();
    chk("pre_idx", 32'(idx), 0);
    chk("pre_err", 32'(err), 0);
    mode = 1'b1; div = 8'd2;
    for (int s = 1; s <= 10; s++) begin
      repeat (2) begin
        tick();
        chk("scn_hidx", 32'(idx), (s - 1) % 10);
        chk("scn_hout", 32'(out_n),
            32'(dec((s - 1) % 10)));
        chk("scn_hwrap", 32'(wrap), 0);
      end
      tick();
      chk("scn_idx", 32'(idx), s % 10);
      chk("scn_out", 32'(out_n), 32'(sout(s % 10)));
      chk("scn_wrap", 32'(wrap), (s == 10) ? 1 : 0);
    end
    tick();
    chk("wrap_end", 32'(wrap), 0);

    // 4: load mid-period, then illegal load
    load = 1'b1; code_in = 4'd7;
    tick();
    load = 1'b0;
    chk("ld_idx", 32'(idx), 7);
    chk("ld_out", 32'(out_n), 32'(sout(7)));
    chk("ld_err", 32'(err), 0);
    repeat (2) begin
      tick();
      chk("ld_hidx", 32'(idx), 7);
      chk("ld_hout", 32'(out_n), 32'(dec(7)));
    end
    tick();
    chk("ld_step", 32'(idx), 8);
    load = 1'b1; code_in = 4'd12;
    tick();
    load = 1'b0;
    chk("bad_idx", 32'(idx), 0);
    chk("bad_err", 32'(err), 1);
    chk("bad_out", 32'(out_n), 32'(sout(0)));

    // 5: en drop with prescaler held at 1
    tick();
    en = 1'b0;
    repeat (5) begin
      tick();
      chk("en0_out", 32'(out_n), 32'h3FF);
      chk("en0_idx", 32'(idx), 0);
      chk("en0_wrap", 32'(wrap), 0);
    end
    en = 1'b1;
    tick();
    chk("en1_out", 32'(out_n), 32'(dec(0)));
    chk("en1_idx", 32'(idx), 0);
    tick();
    chk("en1_step", 32'(idx), 1);
    chk("en1_sout", 32'(out_n), 32'(sout(1)));
    chk("en1_err", 32'(err), 1);
    reset = 1'b1;
    tick();
    chk("mrst_out", 32'(out_n), 32'h3FF);
    chk("mrst_idx", 32'(idx), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_wrap", 32'(wrap), 0);

    // 6: div=3, step period 4 (blank cycle if enabled)
    reset = 1'b0; div = 8'd3;
    for (int p = 1; p <= 3; p++) begin
      repeat (3) begin
        tick();
        chk("d3_hidx", 32'(idx), p - 1);
        chk("d3_hout", 32'(out_n), 32'(dec(p - 1)));
      end
      tick();
      chk("d3_idx", 32'(idx), p);
      chk("d3_out", 32'(out_n), 32'(sout(p)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_nofm_scan.md
Name: decoder_nofm_scan

Overview:
Parametrised, registered one-of-N active-low decoder for the sound-board glue logic. It generalises the 4-to-10 BCD decoder to IN_W-bit codes and OUT_N outputs, with an enable and out-of-range error flag. It adds a scan mode in which an internal prescaled counter steps the active output through 0..OUT_N-1, for strobe multiplexing without a CPU write per step.

Parameters:
IN_W, 4, code width in bits
OUT_N, 10, number of active-low outputs; legal range 2..2**IN_W, and elaboration fails outside it
DIV_W, 8, width of the prescaler divide value

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  1 = outputs live; 0 = all outputs forced high, state held
mode  in  1  0 = direct decode of code_in; 1 = scan
code_in  in  IN_W  direct-mode code; scan-mode load value
load  in  1  scan mode: jump index to code_in
div  in  DIV_W  scan step period is div+1 clk cycles
out_n  out  OUT_N  active-low one-hot output, registered
idx  out  IN_W  index currently driven on out_n
wrap  out  1  one-cycle pulse when scan index wraps OUT_N-1 -> 0
err  out  1  direct mode: registered code_in >= OUT_N; scan load of an illegal code

Behaviour:
- Reset (synchronous, active-high; clock is clk): out_n = all ones, idx = 0, prescaler = 0, wrap = 0, err = 0. Reset overrides every other input, including mid-scan.
- decode(k): bit k low, all other bits high. If k >= OUT_N, all bits are high (no output asserted).
- All outputs are registered. out_n and idx change on the same edge and are always mutually consistent (out_n == decode(idx) whenever en=1 and err=0).
- en=0: out_n <= all ones, wrap <= 0. idx, prescaler and err hold. When en returns to 1, out_n <= decode(idx) on the next edge.
- mode=0, direct, 1-cycle latency: out_n <= decode(code_in); err <= (code_in >= OUT_N); idx <= code_in if it is in range, else idx holds. Prescaler held at 0. wrap = 0. load is ignored.
- mode=1, scan:
  - Prescaler counts 0..div. On the cycle it equals div it returns to 0 and a step occurs. div=0 steps every cycle.
  - A change to div takes effect on the next compare. If the prescaler is already above the new div, it counts up to 2**DIV_W-1, wraps to 0 and then steps.
  - Step: idx <= (idx == OUT_N-1) ? 0 : idx+1. wrap <= 1 on the wrapping step only, otherwise 0.
  - load=1 (priority over step): idx <= code_in if it is in range, else idx <= 0 and err <= 1. Prescaler <= 0. wrap <= 0. A legal load clears err.
  - out_n <= decode(next idx).
  - err is otherwise unchanged by stepping.
- Mode 0 -> 1 transition: scan starts from the current idx with the prescaler cleared; the first step occurs div+1 cycles later.
- Mode 1 -> 0 transition: the next edge performs a direct decode; err is recomputed from code_in.
- All counter arithmetic is unsigned and sized; no width-extended overflow paths.

Optional Feature:
Macro: DECODER_SCAN_BLANK_EN
- Defined: each scan step (including wrap and load) inserts break-before-make. On the step edge out_n <= all ones while idx advances. On the following edge out_n <= decode(idx). The step period is unchanged (requires div >= 1; with div=0 out_n stays all ones in scan). Direct mode is unaffected.
- Undefined: no blank cycle; out_n switches directly from one asserted output to the next.

Test Plan:
1. Reset held 3 cycles with mode=0, en=1, code_in=3 -> out_n=10'h3FF, idx=0, err=0. Release reset -> 1 cycle later out_n=10'b1111110111, idx=3.
2. Direct sweep of code_in 0..15, one per cycle -> out_n lags one cycle. Codes 0..9 give a single 0 at bit k. Codes 10..15 give out_n=10'h3FF, err=1, and idx stays at 9.
3. Scan with div=2 from idx=0 -> idx steps every 3 cycles: 0,1,...,9,0. wrap is high for exactly one cycle on the 9->0 edge; period is 30 cycles.
4. Scan with load=1, code_in=7, asserted mid-period -> next edge idx=7, out_n bit 7 low, prescaler restarted with the next step 3 cycles later. load with code_in=12 -> idx=0, err=1.
5. Scan with en dropped for 5 cycles -> out_n=10'h3FF and idx frozen. en restored -> scan resumes with the prescaler at its held count. Reset asserted mid-scan -> all outputs return to reset values.
6. With DECODER_SCAN_BLANK_EN defined, div=3 -> at each step one cycle of out_n=10'h3FF, then decode(idx) held for 3 cycles. Step period is still 4 cycles.
